aes_128_stream_ctrl: RTL

- Valid/ready streaming shell around the fully pipelined aes_128 core.
- The core has no valid, no stall and no reset. This block registers accepted requests into the core's state/key inputs, tracks each in-flight request with a LATENCY-deep valid/tag shift line, and captures core results into an output FIFO.
- Input acceptance is credit-limited so no result is ever dropped under downstream back-pressure.
- Placement: directly upstream and downstream of aes_128.

---
 rtl/aes_128_stream_ctrl_if.sv | 24 ++
 rtl/aes_128_stream_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/aes_128_stream_ctrl_if.sv
// Request/response stream bundle between a client and aes_128_stream_ctrl.
interface aes_128_stream_ctrl_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    logic [127:0]     in_key;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_state, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_state, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/aes_128_stream_ctrl.sv
// Valid/ready shell around the stall-free aes_128 pipeline: input regs,
// in-flight valid/tag tracker, credit-limited intake and a FWFT result FIFO.
module aes_128_stream_ctrl #(
    parameter int LATENCY = 21,
    parameter int DEPTH   = 32,
    parameter int TAG_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    aes_128_stream_ctrl_if.slave bus,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0]   LIMIT = DEPTH[CW:0];
    localparam logic [CW-1:0] FULL  = DEPTH[CW-1:0];

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } trk_t;

    trk_t             trk [LATENCY+1];
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [127:0]     mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic [CW:0]      credit;
    logic             accept;
    logic             wr_en;
    logic             pop;

    // Credit counts everything that will eventually occupy a FIFO slot.
    assign credit       = {1'b0, inflight} + {1'b0, fifo_count};
    assign bus.in_ready = credit < LIMIT;
    assign accept       = bus.in_valid & bus.in_ready;
    assign wr_en        = trk[LATENCY].valid;
    assign bus.out_valid = fifo_count != '0;
    assign pop          = bus.out_valid & bus.out_ready;
    assign bus.out_data = mem_data[rd_ptr];
    assign bus.out_tag  = mem_tag[rd_ptr];
    assign busy         = (inflight != '0) | (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_state <= '0;
            core_key   <= '0;
        end else if (accept) begin
            core_state <= bus.in_state;
            core_key   <= bus.in_key;
        end
    end

    // The core never stalls, so the tracker shifts every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LATENCY; i++) begin
                trk[i] <= '0;
            end
        end else begin
            trk[0].valid <= accept;
            if (accept) begin
                trk[0].tag <= bus.in_tag;
            end
            for (int i = 1; i <= LATENCY; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({accept, wr_en})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: only slots below fifo_count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= core_out;
            mem_tag[wr_ptr]  <= trk[LATENCY].tag;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(wr_en && fifo_count == FULL)
    );
endmodule
